dff_delay_line: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register delay line.
- Adds the following, none of which the single flop has:
  - clock enable (stall)
  - per-stage valid tracking
  - flush
  - run-time selectable tap
  - occupancy count
- Used wherever data must be retimed by a fixed or selectable number of cycles, e.g. aligning a datapath against a slower control path.

---
 rtl/dff_delay_line_pkg.sv | 35 +++
 rtl/dff_delay_line_stage.sv | 31 +++
 rtl/dff_delay_line.sv | 83 ++++++++
 tb/tb_dff_delay_line.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_delay_line_pkg.sv
// Shared width helpers and index types for the parametrised register delay line.
package dff_delay_line_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Constant-evaluable ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Tap selector width never collapses to zero bits, even for a single stage.
  function automatic int tap_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // The occupancy count must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

  localparam int DEFAULT_TSW = tap_width(DEFAULT_DEPTH);
  localparam int DEFAULT_CW  = cnt_width(DEFAULT_DEPTH);

  typedef logic [DEFAULT_TSW-1:0] stage_idx_t;
  typedef logic [DEFAULT_CW-1:0]  fill_cnt_t;

endpackage

// File: rtl/dff_delay_line_stage.sv
// One delay-line stage: a WIDTH-bit data register paired with its valid bit.
module dff_stage
  import dff_delay_line_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  // clr drops only the valid bit; the stale data stays so q keeps its old value.
  always_ff @(posedge c) begin
    if (r) begin
      q     <= RST_VAL;
      q_vld <= 1'b0;
    end else if (clr) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/dff_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with stall, flush, valid tracking,
// a run-time selectable tap and an occupancy count.
module dff_delay_line
  import dff_delay_line_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               DEPTH   = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              TSW     = tap_width(DEPTH),
  localparam int              CW      = cnt_width(DEPTH)
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic [TSW-1:0]   tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [WIDTH-1:0] tap,
  output logic             tap_vld,
  output logic [CW-1:0]    fill_cnt
);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic             in_vld;

    if (i == 0) begin : g_head
      assign in_data = d;
      assign in_vld  = d_vld;
    end else begin : g_body
      assign in_data = stage_data[i-1];
      assign in_vld  = stage_vld[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .c     (c),
      .r     (r),
      .en    (en),
      .clr   (flush),
      .d     (in_data),
      .d_vld (in_vld),
      .q     (stage_data[i]),
      .q_vld (stage_vld[i])
    );
  end

  // Incremental count: one sample may enter and one may leave per shift,
  // which keeps it equal to the popcount of stage_vld without an adder tree.
  always_ff @(posedge c) begin
    if (r) begin
      fill_cnt <= '0;
    end else if (flush) begin
      fill_cnt <= '0;
    end else if (en) begin
      fill_cnt <= fill_cnt + CW'(d_vld) - CW'(stage_vld[DEPTH-1]);
    end
  end

  assign q     = stage_data[DEPTH-1];
  assign q_vld = stage_vld[DEPTH-1];

  // Selectors beyond the last stage fall through to the reset value, invalid.
  always_comb begin
    tap     = RST_VAL;
    tap_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TSW'(i)) begin
        tap     = stage_data[i];
        tap_vld = stage_vld[i];
      end
    end
  end

endmodule

// File: tb/tb_dff_delay_line.sv
// Directed plus short random checks of dff_delay_line against a queue-based scoreboard.
module tb_dff_delay_line;
  import dff_delay_line_pkg::*;

  localparam int               DEPTH = 4;
  localparam logic [7:0]       RSTV  = 8'hA5;

  logic       c = 1'b0;
  logic       r, en, flush, d_vld;
  logic [7:0] d;
  stage_idx_t tap_sel;
  logic [7:0] q, tap;
  logic       q_vld, tap_vld;
  fill_cnt_t  fill_cnt;

  logic [1:0] tap_sel3;
  logic [7:0] q3, tap3;
  logic       q_vld3, tap_vld3;
  logic [1:0] fill_cnt3;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [7:0] q;
    logic       q_vld;
    int         cnt;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_data [DEPTH];
  logic       m_vld  [DEPTH];

  dff_delay_line #(.WIDTH(8), .DEPTH(DEPTH), .RST_VAL(RSTV)) u_dut (
    .c(c), .r(r), .en(en), .flush(flush), .d(d), .d_vld(d_vld), .tap_sel(tap_sel),
    .q(q), .q_vld(q_vld), .tap(tap), .tap_vld(tap_vld), .fill_cnt(fill_cnt)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3), .RST_VAL(RSTV)) u_dut3 (
    .c(c), .r(r), .en(en), .flush(flush), .d(d), .d_vld(d_vld), .tap_sel(tap_sel3),
    .q(q3), .q_vld(q_vld3), .tap(tap3), .tap_vld(tap_vld3), .fill_cnt(fill_cnt3)
  );

  always #5 c = ~c;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drives one edge's inputs, advances the reference model, queues the expectation.
  task automatic applyStimulus(input logic rr, input logic ee, input logic ff,
                               input logic [7:0] dd, input logic vv);
    int pop;
    r = rr; en = ee; flush = ff; d = dd; d_vld = vv;
    if (rr) begin
      for (int i = 0; i < DEPTH; i++) begin m_data[i] = RSTV; m_vld[i] = 1'b0; end
    end else if (ff) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    end else if (ee) begin
      for (int i = DEPTH - 1; i > 0; i--) begin m_data[i] = m_data[i-1]; m_vld[i] = m_vld[i-1]; end
      m_data[0] = dd;
      m_vld[0]  = vv;
    end
    pop = 0;
    for (int i = 0; i < DEPTH; i++) pop += int'(m_vld[i]);
    sb.push_back('{q: m_data[DEPTH-1], q_vld: m_vld[DEPTH-1], cnt: pop});
    @(posedge c);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    n_vec++;
    assert (sb.size() != 0) else begin
      n_miss++;
      $error("[TB] FAIL %s.sb: observed empty expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkValue($sformatf("%s.q", tag), 32'(q), 32'(e.q));
      checkValue($sformatf("%s.q_vld", tag), 32'(q_vld), 32'(e.q_vld));
      checkValue($sformatf("%s.fill", tag), 32'(fill_cnt), e.cnt);
      checkValue($sformatf("%s.tap", tag), 32'(tap), 32'(m_data[tap_sel]));
      checkValue($sformatf("%s.tap_vld", tag), 32'(tap_vld), 32'(m_vld[tap_sel]));
    end
  endtask

  task automatic tapCheck(input string tag, input logic [1:0] sel,
                          input logic [7:0] exp_d, input logic exp_v);
    tap_sel = sel;
    #1;
    checkValue($sformatf("%s.tap%0d", tag, sel), 32'(tap), 32'(exp_d));
    checkValue($sformatf("%s.tap_vld%0d", tag, sel), 32'(tap_vld), 32'(exp_v));
  endtask

  initial begin
    logic [7:0] stream [5];
    int         fills  [5];
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    fills  = '{1, 2, 3, 4, 4};
    r = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_vld = 1'b0;
    tap_sel = '0; tap_sel3 = 2'd3;
    for (int i = 0; i < DEPTH; i++) begin m_data[i] = 'x; m_vld[i] = 1'bx; end
    @(negedge c);

    // Reset
    applyStimulus(1, 1, 1, 8'h33, 1); checkOutput("rst0");
    applyStimulus(1, 0, 0, 8'h00, 0); checkOutput("rst1");
    checkValue("rst.q", 32'(q), 32'hA5);
    checkValue("rst.q_vld", 32'(q_vld), 0);
    checkValue("rst.fill", 32'(fill_cnt), 0);
    for (int s = 0; s < 4; s++) tapCheck("rst", 2'(s), 8'hA5, 1'b0);
    checkValue("rst.d3_tap3", 32'(tap3), 32'hA5);
    checkValue("rst.d3_tap_vld3", 32'(tap_vld3), 0);

    // Streaming
    tap_sel = 2'd1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, stream[k], 1);
      checkOutput($sformatf("stream%0d", k));
      checkValue($sformatf("stream%0d.fill_c", k), 32'(fill_cnt), fills[k]);
      if (k == 3) begin
        checkValue("stream3.q_c", 32'(q), 32'h01);
        checkValue("stream3.q_vld_c", 32'(q_vld), 1);
      end
      if (k == 4) checkValue("stream4.q_c", 32'(q), 32'h02);
    end

    // Stall
    applyStimulus(0, 0, 1, 8'h00, 0); checkOutput("stall_flush");
    applyStimulus(0, 1, 0, 8'h11, 1); checkOutput("stall_ld0");
    applyStimulus(0, 1, 0, 8'h22, 1); checkOutput("stall_ld1");
    applyStimulus(0, 1, 0, 8'h33, 1); checkOutput("stall_ld2");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 8'hEE, 1);
      checkOutput($sformatf("hold%0d", k));
      checkValue($sformatf("hold%0d.fill_c", k), 32'(fill_cnt), 3);
    end
    applyStimulus(0, 1, 0, 8'h00, 0); checkOutput("resume0");
    checkValue("resume0.q_c", 32'(q), 32'h11);
    checkValue("resume0.q_vld_c", 32'(q_vld), 1);
    checkValue("resume0.fill_c", 32'(fill_cnt), 3);
    applyStimulus(0, 1, 0, 8'h00, 0); checkOutput("resume1");
    checkValue("resume1.fill_c", 32'(fill_cnt), 2);

    // Flush priority over shift
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 0, 8'(8'h81 + k), 1);
      checkOutput($sformatf("fl_ld%0d", k));
    end
    checkValue("fl_pre.fill_c", 32'(fill_cnt), 4);
    applyStimulus(0, 1, 1, 8'hFF, 1); checkOutput("flush");
    checkValue("flush.fill_c", 32'(fill_cnt), 0);
    checkValue("flush.q_vld_c", 32'(q_vld), 0);
    checkValue("flush.q_c", 32'(q), 32'h81);
    for (int s = 0; s < 4; s++) tapCheck("flush", 2'(s), 8'(8'h84 - s), 1'b0);

    // Tap select
    applyStimulus(0, 1, 0, 8'h10, 1); checkOutput("tp0");
    applyStimulus(0, 1, 0, 8'h20, 1); checkOutput("tp1");
    applyStimulus(0, 1, 0, 8'h30, 1); checkOutput("tp2");
    applyStimulus(0, 1, 0, 8'h40, 1); checkOutput("tp3");
    applyStimulus(0, 0, 0, 8'hFF, 1); checkOutput("tp_hold");
    tapCheck("tsel", 2'd0, 8'h40, 1'b1);
    tapCheck("tsel", 2'd1, 8'h30, 1'b1);
    tapCheck("tsel", 2'd2, 8'h20, 1'b1);
    tapCheck("tsel", 2'd3, 8'h10, 1'b1);
    tap_sel3 = 2'd3; #1;
    checkValue("d3.oor_tap", 32'(tap3), 32'hA5);
    checkValue("d3.oor_tap_vld", 32'(tap_vld3), 0);
    tap_sel3 = 2'd2; #1;
    checkValue("d3.tap2", 32'(tap3), 32'h20);
    checkValue("d3.tap_vld2", 32'(tap_vld3), 1);
    checkValue("d3.q", 32'(q3), 32'h20);
    checkValue("d3.q_vld", 32'(q_vld3), 1);
    checkValue("d3.fill", 32'(fill_cnt3), 3);

    // Reset mid-operation
    applyStimulus(0, 0, 1, 8'h00, 0); checkOutput("mr_flush");
    applyStimulus(0, 1, 0, 8'h51, 1); checkOutput("mr_ld0");
    applyStimulus(0, 1, 0, 8'h52, 1); checkOutput("mr_ld1");
    checkValue("mr_pre.fill_c", 32'(fill_cnt), 2);
    applyStimulus(1, 1, 0, 8'h99, 1); checkOutput("mr_rst");
    checkValue("mr_rst.fill_c", 32'(fill_cnt), 0);
    for (int s = 0; s < 4; s++) tapCheck("mr_rst", 2'(s), 8'hA5, 1'b0);
    applyStimulus(0, 1, 0, 8'h7E, 1); checkOutput("mr_post");
    tapCheck("mr_post", 2'd0, 8'h7E, 1'b1);
    checkValue("mr_post.fill_c", 32'(fill_cnt), 1);

    // Random mix of stalls, bubbles, flushes and occasional resets
    for (int k = 0; k < 60; k++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 11) == 0, 8'($urandom), 1'($urandom));
      tap_sel = 2'($urandom);
      #1;
      checkOutput($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
